// File: rtl/rf_mp_if.sv
// Register-file bus: read ports, two writeback ports and the issue/scoreboard request.
// The master drives addresses, write data and issue; the slave returns read data and busy flags.
interface rf_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   raddr_i;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]      busy_o;
  logic [2*AW-1:0]     waddr_i;
  logic [2*XLEN-1:0]   wdata_i;
  logic [1:0]          we_i;
  logic [1:0]          wclr_i;
  logic                issue_i;
  logic [AW-1:0]       issue_addr_i;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, wclr_i, issue_i, issue_addr_i,
    input  rdata_o, busy_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, wclr_i, issue_i, issue_addr_i,
    output rdata_o, busy_o
  );
endinterface

// File: rtl/rf_mp.sv
// Multi-port register file with two writeback ports, write-to-read bypass
// and a per-register busy scoreboard for hazard detection.
module rf_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic    clk_i,
  input  logic    reset,
  rf_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic [AW-1:0]   w_waddr [2];
  logic [XLEN-1:0] w_wdata [2];
  logic [1:0]      w_wen;
  logic [1:0]      w_wclr;
  logic            w_issue;
  logic [AW-1:0]   w_raddr [NRD];
  logic [XLEN-1:0] w_rdata [NRD];
  logic [NRD-1:0]  w_busy;

  // Writes and issues aimed at a hard-wired zero register are dropped here,
  // so storage, scoreboard and bypass all see the same filtered requests.
  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      w_waddr[k] = bus.waddr_i[k*AW +: AW];
      w_wdata[k] = bus.wdata_i[k*XLEN +: XLEN];
      w_wen[k]   = bus.we_i[k] && !((ZERO_REG != 0) && (w_waddr[k] == '0));
      w_wclr[k]  = w_wen[k] && bus.wclr_i[k];
    end
    w_issue = bus.issue_i && !((ZERO_REG != 0) && (bus.issue_addr_i == '0));
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      // Port 1 is applied last so it wins on an address collision.
      for (int unsigned k = 0; k < 2; k++) begin
        if (w_wen[k]) begin
          r_regs[w_waddr[k]] <= w_wdata[k];
        end
      end
      for (int unsigned k = 0; k < 2; k++) begin
        if (w_wclr[k]) begin
          r_busy[w_waddr[k]] <= 1'b0;
        end
      end
      // A newer producer issued in the same cycle outranks the retiring one.
      if (w_issue) begin
        r_busy[bus.issue_addr_i] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NRD; p++) begin
      w_raddr[p] = bus.raddr_i[p*AW +: AW];
      w_rdata[p] = r_regs[w_raddr[p]];
      w_busy[p]  = r_busy[w_raddr[p]];
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < 2; k++) begin
          if (w_wen[k] && (w_waddr[k] == w_raddr[p])) begin
            w_rdata[p] = w_wdata[k];
            if (w_wclr[k]) begin
              w_busy[p] = 1'b0;
            end
          end
        end
      end
      if ((ZERO_REG != 0) && (w_raddr[p] == '0)) begin
        w_rdata[p] = '0;
        w_busy[p]  = 1'b0;
      end
      if (reset) begin
        w_rdata[p] = '0;
        w_busy[p]  = 1'b0;
      end
    end
  end

  always_comb begin
    bus.rdata_o = '0;
    bus.busy_o  = w_busy;
    for (int unsigned p = 0; p < NRD; p++) begin
      bus.rdata_o[p*XLEN +: XLEN] = w_rdata[p];
    end
  end
endmodule

// File: tb/tb_rf_mp.sv
// Randomised and directed bench for rf_mp: expected read data/busy per cycle
// come from an array model and are checked by a separate monitor via a queue.
module tb_rf_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk_i = 1'b0;
  logic reset = 1'b1;
  always #5 clk_i = ~clk_i;

  rf_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  rf_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk_i(clk_i),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [NRD*XLEN-1:0] d;
    logic [NRD-1:0]      b;
    int                  step;
  } exp_t;

  exp_t q[$];
  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];
  int vectors     = 0;
  int miscompares = 0;
  int step        = 0;

  // Drive one cycle of stimulus, predict this cycle's outputs, then advance the
  // model to the state that the following rising edge produces.
  task automatic apply(input bit rst, input bit [4:0] ra0, input bit [4:0] ra1,
                       input bit [1:0] we, input bit [1:0] wclr,
                       input bit [4:0] wa0, input bit [4:0] wa1,
                       input bit [31:0] wd0, input bit [31:0] wd1,
                       input bit iss, input bit [4:0] ia);
    exp_t      e;
    bit [4:0]  ra [2];
    bit [31:0] d;
    bit        b;
    @(negedge clk_i);
    reset            = rst;
    bus.raddr_i      = {ra1, ra0};
    bus.we_i         = we;
    bus.wclr_i       = wclr;
    bus.waddr_i      = {wa1, wa0};
    bus.wdata_i      = {wd1, wd0};
    bus.issue_i      = iss;
    bus.issue_addr_i = ia;
    ra[0] = ra0;
    ra[1] = ra1;
    e.d = '0;
    e.b = '0;
    for (int p = 0; p < NRD; p++) begin
      d = 32'h0;
      b = 1'b0;
      if (!rst && ra[p] != 5'd0) begin
        d = m_reg[ra[p]];
        b = m_busy[ra[p]];
        if (we[1] && wa1 == ra[p]) d = wd1;
        else if (we[0] && wa0 == ra[p]) d = wd0;
        if ((we[0] && wclr[0] && wa0 == ra[p]) || (we[1] && wclr[1] && wa1 == ra[p])) b = 1'b0;
      end
      e.d[p*XLEN +: XLEN] = d;
      e.b[p] = b;
    end
    e.step = step;
    step++;
    q.push_back(e);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_reg[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we[0] && wa0 != 5'd0) m_reg[wa0] = wd0;
      if (we[1] && wa1 != 5'd0) m_reg[wa1] = wd1;
      if (we[0] && wclr[0]) m_busy[wa0] = 1'b0;
      if (we[1] && wclr[1]) m_busy[wa1] = 1'b0;
      if (iss && ia != 5'd0) m_busy[ia] = 1'b1;
    end
  endtask

  task automatic rd(input bit [4:0] ra0, input bit [4:0] ra1);
    apply(1'b0, ra0, ra1, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  // Monitor: outputs are stable 3 time units after the stimulus edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int p = 0; p < NRD; p++) begin
          vectors++;
          if (bus.rdata_o[p*XLEN +: XLEN] !== e.d[p*XLEN +: XLEN]) begin
            miscompares++;
            $display("FAIL rdata step %0d port %0d: got %h expected %h",
                     e.step, p, bus.rdata_o[p*XLEN +: XLEN], e.d[p*XLEN +: XLEN]);
          end
          vectors++;
          if (bus.busy_o[p] !== e.b[p]) begin
            miscompares++;
            $display("FAIL busy step %0d port %0d: got %b expected %b",
                     e.step, p, bus.busy_o[p], e.b[p]);
          end
        end
      end
    end
  end

  initial begin
    int waited;
    bit [1:0] we, wc;
    bus.raddr_i = '0; bus.we_i = '0; bus.wclr_i = '0; bus.waddr_i = '0;
    bus.wdata_i = '0; bus.issue_i = 1'b0; bus.issue_addr_i = '0;
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end

    // Reset state, then all registers read zero
    apply(1'b1, 5'd1, 5'd2, 2'b11, 2'b11, 5'd1, 5'd2, 32'hDEAD, 32'hBEEF, 1'b1, 5'd3);
    for (int i = 0; i < NREGS; i += 2) rd(5'(i), 5'(i + 1));

    // Walk pattern through port 0 with same-cycle bypass read
    for (int i = 1; i < NREGS; i++)
      apply(1'b0, 5'(i), 5'(i - 1), 2'b01, 2'b00, 5'(i), 5'd0,
            32'hA5A5_0000 + 32'(i), 32'h0, 1'b0, 5'd0);
    apply(1'b0, 5'd0, 5'd0, 2'b01, 2'b00, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < NREGS; i++) rd(5'(i), 5'(NREGS - 1 - i));

    // Both ports on one address: port 1 wins
    apply(1'b0, 5'd5, 5'd5, 2'b11, 2'b00, 5'd5, 5'd5, 32'h11, 32'h22, 1'b0, 5'd0);
    rd(5'd5, 5'd4);

    // Disabled write leaves register unchanged
    apply(1'b0, 5'd2, 5'd3, 2'b01, 2'b00, 5'd1, 5'd0, 32'h6, 32'h0, 1'b0, 5'd0);
    apply(1'b0, 5'd1, 5'd1, 2'b00, 2'b00, 5'd1, 5'd1, 32'hF, 32'hF, 1'b0, 5'd0);
    rd(5'd1, 5'd1);

    // Scoreboard: issue, retire with bypass, issue+retire collision, we without wclr
    apply(1'b0, 5'd7, 5'd6, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7);
    rd(5'd7, 5'd6);
    apply(1'b0, 5'd7, 5'd7, 2'b01, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 1'b0, 5'd0);
    rd(5'd7, 5'd0);
    apply(1'b0, 5'd7, 5'd1, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7);
    apply(1'b0, 5'd7, 5'd7, 2'b10, 2'b10, 5'd0, 5'd7, 32'h0, 32'h78, 1'b1, 5'd7);
    rd(5'd7, 5'd7);
    apply(1'b0, 5'd7, 5'd6, 2'b01, 2'b00, 5'd7, 5'd0, 32'h79, 32'h0, 1'b0, 5'd0);
    rd(5'd7, 5'd7);
    apply(1'b0, 5'd0, 5'd7, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0);

    // Reset pulse mid-operation clears state before any clock edge
    apply(1'b0, 5'd3, 5'd4, 2'b11, 2'b00, 5'd3, 5'd4, 32'h33, 32'h44, 1'b1, 5'd9);
    apply(1'b1, 5'd9, 5'd3, 2'b11, 2'b11, 5'd9, 5'd3, 32'h99, 32'h3, 1'b1, 5'd4);
    rd(5'd9, 5'd4);

    // Randomised traffic with concentrated write addresses to provoke collisions
    for (int n = 0; n < 1500; n++) begin
      we = 2'($urandom);
      wc = 2'($urandom);
      apply(($urandom_range(0, 79) == 0), 5'($urandom_range(0, 7)), 5'($urandom),
            we, wc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 7)));
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    #5;
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
